// File: rtl/cordic_ln_core.sv
// cordic_ln_core
//   Iterative hyperbolic-vectoring CORDIC that computes ln(X) = 2*atanh((X-1)/(X+1))
//   on signed Q3.28 data. One micro-rotation is performed per clock using a single
//   shared add/subtract datapath. The shift index sequence is 1,2,3,4,4,5,...,13,13,14,...,ITER,
//   so an operation takes ITER+2 rotation cycles.
//
// Parameters
//   ITER  number of distinct shift indices (legal 14..27, default 24)
//   FRAC  fractional bits of every data word (fixed at 28)
//
// Ports
//   CLK     in   rising-edge clock
//   RST_N   in   asynchronous active-low reset; aborts any operation in flight
//   START   in   start request, sampled only while idle
//   X_IN    in   operand X, signed Q3.28, sampled on the accepting edge only
//   BUSY    out  high while rotations are in progress
//   DONE    out  one-cycle pulse when RESULT/ERR are valid
//   ERR     out  domain error (X < 0.125) for the current result, held until next START
//   RESULT  out  ln(X), signed Q3.28, held until the next DONE
//
// Build option
//   CORDIC_LN_ROUND_EN  when defined, every shifted term is rounded half-up
//                       ((v + 2^(i-1)) >>> i) instead of truncated.

module cordic_ln_core #(
  parameter int ITER = 24,
  parameter int FRAC = 28
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               START,
  input  logic signed [31:0] X_IN,
  output logic               BUSY,
  output logic               DONE,
  output logic               ERR,
  output logic signed [31:0] RESULT
);

  localparam int DATA_W = 32;
  // x starts at X+1, which reaches ~9.0 for the largest legal X and does not fit
  // Q3.28; x therefore carries one extra integer bit. y and z stay 32 bits.
  localparam int XW = DATA_W + 1;
  localparam logic [4:0] LAST_STEP = 5'(ITER + 1);
  localparam logic signed [DATA_W-1:0] ONE   = 1 << FRAC;
  localparam logic signed [DATA_W-1:0] MIN_X = ONE >>> 3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t state;
  state_t state_nx;

  logic signed [XW-1:0]     x;
  logic signed [DATA_W-1:0] y;
  logic signed [DATA_W-1:0] z;
  logic [4:0]               step;

  logic [4:0]               idx;
  logic signed [DATA_W-1:0] t_i;
  logic signed [XW-1:0]     y_ext;
  logic signed [XW-1:0]     x_sh;
  logic signed [XW-1:0]     y_sh;
  logic signed [XW-1:0]     x_nx;
  logic signed [DATA_W-1:0] y_nx;
  logic signed [DATA_W-1:0] z_nx;
  logic                     x_ok;

  // Step counter -> shift index; steps 4 and 14 repeat indices 4 and 13.
  function automatic logic [4:0] shift_idx(input logic [4:0] s);
    if (s <= 5'd3) begin
      return s + 5'd1;
    end else if (s <= 5'd13) begin
      return s;
    end else begin
      return s - 5'd1;
    end
  endfunction

  // round(atanh(2^-i) * 2^28). From i = 10 on the cubic term is below half an
  // LSB, so the table value is exactly 2^(28-i).
  function automatic logic signed [DATA_W-1:0] atanh_rom(input logic [4:0] i);
    case (i)
      5'd1:    return 32'sd147453245;
      5'd2:    return 32'sd68561855;
      5'd3:    return 32'sd33730852;
      5'd4:    return 32'sd16799113;
      5'd5:    return 32'sd8391340;
      5'd6:    return 32'sd4194645;
      5'd7:    return 32'sd2097195;
      5'd8:    return 32'sd1048581;
      5'd9:    return 32'sd524289;
      default: return ONE >>> i;
    endcase
  endfunction

  // Arithmetic right shift of a rotation term, optionally rounded half-up.
  function automatic logic signed [XW-1:0] shr(input logic signed [XW-1:0] v,
                                               input logic [4:0]           sh);
`ifdef CORDIC_LN_ROUND_EN
    logic signed [XW-1:0] half;
    half = XW'(1) << (sh - 5'd1);
    return (v + half) >>> sh;
`else
    return v >>> sh;
`endif
  endfunction

  assign x_ok = (X_IN >= MIN_X);

  // One micro-rotation: d = +1 when y < 0, otherwise -1.
  always_comb begin
    idx   = shift_idx(step);
    t_i   = atanh_rom(idx);
    y_ext = XW'(y);
    x_sh  = shr(x, idx);
    y_sh  = shr(y_ext, idx);
    if (y[DATA_W-1]) begin
      x_nx = x + y_sh;
      y_nx = DATA_W'(y_ext + x_sh);
      z_nx = z - t_i;
    end else begin
      x_nx = x - y_sh;
      y_nx = DATA_W'(y_ext - x_sh);
      z_nx = z + t_i;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (START) begin
          state_nx = x_ok ? RUN : FIN;
        end
      end
      RUN: begin
        if (step == LAST_STEP) begin
          state_nx = FIN;
        end
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    BUSY = (state == RUN);
    DONE = (state == FIN);
  end

  // RESULT is captured on the edge that enters FIN so it is valid with DONE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      x      <= '0;
      y      <= '0;
      z      <= '0;
      step   <= '0;
      ERR    <= 1'b0;
      RESULT <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            if (x_ok) begin
              x    <= XW'(X_IN) + XW'(ONE);
              y    <= X_IN - ONE;
              z    <= '0;
              step <= '0;
              ERR  <= 1'b0;
            end else begin
              ERR    <= 1'b1;
              RESULT <= '0;
            end
          end
        end
        RUN: begin
          x    <= x_nx;
          y    <= y_nx;
          z    <= z_nx;
          step <= step + 5'd1;
          if (step == LAST_STEP) begin
            RESULT <= z_nx <<< 1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_ln_core.sv
// Scoreboard bench for cordic_ln_core: the stimulus side pushes the expected
// ln(X) (from a real-arithmetic reference) for every accepted START, and an
// independent monitor pops and compares whenever DONE is presented.

module tb_cordic_ln_core;

  localparam int ITER     = 24;
  localparam int LAT      = ITER + 3;
  localparam int BUSY_CYC = ITER + 2;
`ifdef CORDIC_LN_ROUND_EN
  localparam longint TOL = 64;
`else
  localparam longint TOL = 256;
`endif

  logic               CLK   = 1'b0;
  logic               RST_N = 1'b1;
  logic               START;
  logic signed [31:0] X_IN;
  logic               BUSY;
  logic               DONE;
  logic               ERR;
  logic signed [31:0] RESULT;

  typedef struct {
    logic signed [31:0] x;
    logic               err;
    longint             val;
    int                 issue;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   issued   = 0;
  int   done_cnt = 0;

  cordic_ln_core #(.ITER(ITER)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .START  (START),
    .X_IN   (X_IN),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .ERR    (ERR),
    .RESULT (RESULT)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Reference: domain check and ln() evaluated in real arithmetic.
  function automatic exp_t model(input logic signed [31:0] x);
    exp_t e;
    real  xr;
    xr      = real'(x) / 268435456.0;
    e.x     = x;
    e.issue = 0;
    if (xr < 0.125) begin
      e.err = 1'b1;
      e.val = 0;
    end else begin
      e.err = 1'b0;
      e.val = longint'($ln(xr) * 268435456.0);
    end
    return e;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp, input longint tol);
    checks++;
    if (act > exp + tol || act < exp - tol) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
    end
  endtask

  task automatic issue(input logic signed [31:0] x);
    exp_t e;
    @(negedge CLK);
    e       = model(x);
    e.issue = cyc;
    sb_q.push_back(e);
    issued++;
    START = 1'b1;
    X_IN  = x;
    @(posedge CLK);
    #1;
    START = 1'b0;
    X_IN  = $urandom;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (DONE !== 1'b1 && n < budget);
    checks++;
    if (DONE !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: DONE not seen within %0d cycles", budget);
    end
  endtask

  // Monitor: compares every DONE against the oldest outstanding expectation.
  initial begin
    int   busy_cnt;
    bit   prev_done;
    exp_t e;
    busy_cnt  = 0;
    prev_done = 1'b0;
    forever begin
      @(negedge CLK);
      if (RST_N !== 1'b1) begin
        busy_cnt  = 0;
        prev_done = 1'b0;
      end else begin
        if (DONE === 1'b1) begin
          done_cnt++;
          chk("done_pulse_width", prev_done, 0, 0);
          chk("busy_low_at_done", BUSY, 0, 0);
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: DONE with no outstanding START, RESULT=%h", RESULT);
          end else begin
            e = sb_q.pop_front();
            chk("err_flag", ERR, e.err, 0);
            chk("result", RESULT, e.val, e.err ? 0 : TOL);
            chk("latency", cyc - e.issue, e.err ? 1 : LAT, 0);
            chk("busy_cycles", busy_cnt, e.err ? 0 : BUSY_CYC, 0);
          end
          busy_cnt = 0;
        end else if (BUSY === 1'b1) begin
          busy_cnt++;
        end
        prev_done = DONE;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    logic signed [31:0] v;
    START = 1'b0;
    X_IN  = '0;
    RST_N = 1'b0;
    #2;
    chk("reset_busy", BUSY, 0, 0);
    chk("reset_done", DONE, 0, 0);
    chk("reset_err", ERR, 0, 0);
    chk("reset_result", RESULT, 0, 0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    // Directed values including the exact lower domain boundary.
    issue(32'sh1000_0000);
    wait_done(LAT + 5);
    issue(32'sh2000_0000);
    wait_done(LAT + 5);
    issue(32'sh0800_0000);
    wait_done(LAT + 5);
    issue(32'sh0200_0000);
    wait_done(LAT + 5);

    // Domain errors.
    issue(32'sh0000_0000);
    wait_done(5);
    repeat (3) @(negedge CLK);
    chk("err_held", ERR, 1, 0);
    chk("err_result_held", RESULT, 0, 0);
    issue(32'sh01FF_FFFF);
    wait_done(5);
    issue(32'shF000_0000);
    wait_done(5);
    issue(32'sh3000_0000);
    @(negedge CLK);
    chk("err_clear_on_start", ERR, 0, 0);
    chk("result_held_during_run", RESULT, 0, 0);
    wait_done(LAT + 5);

    // START while busy is ignored.
    issue(32'sh1800_0000);
    repeat (4) @(negedge CLK);
    START = 1'b1;
    X_IN  = 32'sh6000_0000;
    @(posedge CLK);
    #1;
    START = 1'b0;
    wait_done(LAT + 5);
    repeat (LAT + 3) @(negedge CLK);
    chk("queue_empty_after_ignore", sb_q.size(), 0, 0);

    // START during the DONE cycle is ignored.
    issue(32'sh4000_0000);
    wait_done(LAT + 5);
    START = 1'b1;
    X_IN  = 32'sh0400_0000;
    @(posedge CLK);
    #1;
    START = 1'b0;
    @(negedge CLK);
    chk("start_in_fin_ignored", BUSY, 0, 0);

    // Asynchronous reset mid-operation.
    issue(32'sh5000_0000);
    repeat (9) @(negedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    chk("abort_busy", BUSY, 0, 0);
    chk("abort_done", DONE, 0, 0);
    chk("abort_err", ERR, 0, 0);
    chk("abort_result", RESULT, 0, 0);
    sb_q.delete();
    issued--;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    issue(32'sh0C00_0000);
    wait_done(LAT + 5);

    // Back-to-back random sweep across the legal domain, endpoints included.
    for (int k = 0; k < 64; k++) begin
      if (k == 0) begin
        v = 32'sh0200_0000;
      end else if (k == 63) begin
        v = 32'sh7FFF_FFFF;
      end else begin
        v = $urandom_range(32'h7FFF_FFFF, 32'h0200_0000);
      end
      issue(v);
      wait_done(LAT + 5);
    end

    repeat (5) @(negedge CLK);
    chk("all_starts_done", done_cnt, issued, 0);
    chk("scoreboard_drained", sb_q.size(), 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cordic_ln_core.md
Name: cordic_ln_core

Overview:
- Iterative hyperbolic-vectoring CORDIC engine computing ln(X) = 2*atanh((X-1)/(X+1)) on 32-bit signed fixed point.
- Sits directly downstream of the 32-bit subtract/add operand stage. It consumes X-1 and X+1 as its initial y/x registers and reuses the same add/subtract datapath every iteration.
- Start/busy/done handshake toward the range-reduction controller.

Parameters:
- ITER, 24, number of distinct shift indices i = 1..ITER. Legal range 14..27.
- FRAC, 28, fractional bits of all data words (Q3.28 signed). Fixed; not for override.

Ports:
- CLK  input  1  clock, rising edge
- RST_N  input  1  asynchronous active-low reset
- START  input  1  request; sampled only in IDLE
- X_IN  input  32  operand X, signed Q3.28
- BUSY  output  1  high while an operation is in progress
- DONE  output  1  one-cycle pulse when RESULT is valid
- ERR  output  1  domain error for the current result; held until the next START
- RESULT  output  32  ln(X), signed Q3.28; held until the next DONE

Behaviour:
- Interface: one clock, CLK. Reset RST_N is asynchronous and active-low.
- Reset values: BUSY=0, DONE=0, ERR=0, RESULT=0. Internal x/y/z and the step counter are cleared, state=IDLE. Asserting RST_N low mid-operation aborts immediately; no DONE is produced.
- States: IDLE, RUN, FIN.
- IDLE, START=1 and X_IN >= 0x0200_0000 (0.125):
  - load x=X_IN+1.0, y=X_IN-1.0, z=0, step=0, ERR=0.
  - BUSY=1, go to RUN.
- IDLE, START=1 and X_IN < 0x0200_0000 (includes zero and negative):
  - ERR=1, RESULT=0, go to FIN without iterating.
- RUN: one micro-rotation per cycle.
  - Shift index sequence: 1, 2, 3, 4, 4, 5, ..., 13, 13, 14, ..., ITER. Indices 4 and 13 are repeated.
  - Total steps S = ITER+2 (26 at default).
  - d = +1 if y<0, else -1.
  - x' = x + d*(y>>>i); y' = y + d*(x>>>i); z' = z - d*T[i].
  - T[i] = round(atanh(2^-i)*2^28), a constant ROM.
  - All shifts are arithmetic; all adds are 32-bit two's complement with no saturation. In-range operands never overflow.
- Last RUN step: go to FIN.
- FIN:
  - RESULT = z<<1 (or 0 on error); DONE=1 for exactly this cycle; BUSY=0.
  - Next state IDLE.
- Latency: START edge to DONE visible = S+1 cycles (27 at default); error path = 1 cycle.
- START while BUSY or in FIN is ignored, with no queuing. START may be asserted in the same cycle DONE falls (the next IDLE cycle).
- X_IN is sampled only on the accepting edge; later changes do not affect the operation.
- Accuracy: |RESULT - ln(X)*2^28| <= 256 LSB for 0.125 <= X < 8.

Optional Feature:
- Macro: CORDIC_LN_ROUND_EN.
- Defined: every shifted term uses round-half-up, (v + 2^(i-1)) >>> i, for both x and y updates. Required accuracy tightens to <= 64 LSB.
- Undefined: plain truncating arithmetic shift. Accuracy limit 256 LSB.
- Latency, ports and handshake are identical in both builds.

Test Plan:
- Reset: RST_N low -> BUSY=0, DONE=0, ERR=0, RESULT=0. Release, then START with X_IN=0x1000_0000 (1.0) -> DONE 27 cycles later, RESULT within ±256 LSB of 0, ERR=0.
- X_IN=0x2000_0000 (2.0) -> RESULT = 0x0B17_217F ±256; X_IN=0x0800_0000 (0.5) -> RESULT = 0xF4E8_DE81 ±256. DONE is a single-cycle pulse, BUSY high for cycles 1..26.
- X_IN=0x0000_0000 and X_IN=0xF000_0000 -> DONE after 1 cycle, ERR=1, RESULT=0. Next valid START clears ERR.
- START pulsed again at cycle 5 of RUN with a different X_IN -> ignored; RESULT matches the first operand, exactly one DONE.
- RST_N asserted at cycle 10 of RUN -> outputs 0 asynchronously, no DONE. New START after release completes normally.
- Sweep 64 values 0.125..7.99, back-to-back (START on the cycle after DONE) -> every result within tolerance, 1 DONE per START. Repeat with CORDIC_LN_ROUND_EN defined at ±64 LSB.
